// File: rtl/reset_ctrl_if.sv
// Reset controller signal bundle: asynchronous reset sources in, sequenced resets and status out.
// The controller side (master) drives the resets; the system side (slave) supplies the triggers.
interface reset_ctrl_if;
    logic       pll_locked_i;
    logic       ext_btn_ni;
    logic       sw_rst_req_i;
    logic       rst_periph_no;
    logic       rst_core_no;
    logic [3:0] rst_cause_o;
    logic       ready_o;

    modport master (
        input  pll_locked_i, ext_btn_ni, sw_rst_req_i,
        output rst_periph_no, rst_core_no, rst_cause_o, ready_o
    );

    modport slave (
        output pll_locked_i, ext_btn_ni, sw_rst_req_i,
        input  rst_periph_no, rst_core_no, rst_cause_o, ready_o
    );
endinterface

// File: rtl/reset_ctrl.sv
// Reset sequencer: synchronizes/debounces reset sources, then releases peripheral and core
// resets in a staggered order and records which source caused the most recent reset.
module reset_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    reset_ctrl_if.master io
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "reset_ctrl: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $fatal(1, "reset_ctrl: DEBOUNCE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "reset_ctrl: HOLD_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_bad_stagger
        $fatal(1, "reset_ctrl: STAGGER_CYCLES must be >= 1");
    end

    // HOLD and REL_PERIPH never overlap, so one counter serves both.
    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ASSERT     = 2'd0,
        HOLD       = 2'd1,
        REL_PERIPH = 2'd2,
        RUN        = 2'd3
    } state_e;

    // ---------------- input synchronizers ----------------
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic                   lock_s;
    logic                   btn_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_sync_q <= '0;
            btn_sync_q  <= '1;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], io.pll_locked_i};
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], io.ext_btn_ni};
        end
    end

    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign btn_s  = btn_sync_q[SYNC_STAGES-1];

    // ---------------- button debounce ----------------
    logic [DB_W-1:0] db_cnt_q;
    logic            btn_db_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_cnt_q <= '0;
            btn_db_q <= 1'b1;
        end else if (btn_s == btn_db_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_q <= btn_s;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
        end
    end

    // ---------------- triggers ----------------
    logic pll_loss;
    logic btn_trig;
    logic sw_trig;
    logic any_trig;

    assign pll_loss = ~lock_s;
    assign btn_trig = ~btn_db_q;
    assign sw_trig  = io.sw_rst_req_i;
    assign any_trig = pll_loss | btn_trig | sw_trig;

    // ---------------- sequencing FSM ----------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_periph_q;
    logic             rst_core_q;
    logic [3:0]       cause_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            // A software pulse while already in reset has nothing to add, so only
            // the level-type sources keep us here.
            ASSERT: begin
                cnt_d = '0;
                if (!pll_loss && !btn_trig) state_d = HOLD;
            end
            HOLD: begin
                if (any_trig) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = REL_PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REL_PERIPH: begin
                if (any_trig) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == STAGGER_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (any_trig) state_d = ASSERT;
            end
            default: begin
                state_d = ASSERT;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset outputs are decoded from the next state so they change on the transition edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ASSERT;
            cnt_q        <= '0;
            rst_periph_q <= 1'b0;
            rst_core_q   <= 1'b0;
            cause_q      <= 4'b0001;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_periph_q <= (state_d == REL_PERIPH) || (state_d == RUN);
            rst_core_q   <= (state_d == RUN);
            if ((state_q != ASSERT) && (state_d == ASSERT))
                cause_q <= {sw_trig, btn_trig, pll_loss, 1'b0};
        end
    end

    assign io.rst_periph_no = rst_periph_q;
    assign io.rst_core_no   = rst_core_q;
    assign io.rst_cause_o   = cause_q;
    assign io.ready_o       = (state_q == RUN);

endmodule

// File: tb/tb_reset_ctrl.sv
// Directed bench for reset_ctrl: per-cycle vector tables for the release sequences plus
// hand-written sequences for asynchronous reset assertion mid-sequence.
module tb_reset_ctrl;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;

    reset_ctrl_if rif();

    reset_ctrl #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES    (4),
        .STAGGER_CYCLES (2)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .io    (rif.master)
    );

    always #5 clk_i = ~clk_i;

    // One row = inputs driven for a cycle, outputs expected just after that cycle's edge.
    typedef struct packed {
        logic [2:0] ph;
        logic       rst_n;
        logic       pll;
        logic       btn;
        logic       sw;
        logic       periph;
        logic       core;
        logic       ready;
        logic [3:0] cause;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic string ph_name(input logic [2:0] ph);
        case (ph)
            3'd0:    return "power_on";
            3'd1:    return "pll_loss";
            3'd2:    return "btn_bounce";
            3'd3:    return "btn_hold";
            3'd4:    return "sw_and_sim";
            default: return "recover";
        endcase
    endfunction

    task automatic add(input int n, input logic [2:0] ph,
                       input logic rst_n, input logic pll, input logic btn, input logic sw,
                       input logic periph, input logic core, input logic ready,
                       input logic [3:0] cause);
        for (int i = 0; i < n; i++)
            tbl.push_back({ph, rst_n, pll, btn, sw, periph, core, ready, cause});
    endtask

    task automatic check(input string nm, input int idx,
                         input logic periph, input logic core, input logic ready,
                         input logic [3:0] cause);
        n_vec++;
        if (rif.rst_periph_no !== periph || rif.rst_core_no !== core ||
            rif.ready_o !== ready || rif.rst_cause_o !== cause) begin
            n_err++;
            $display("FAIL %s #%0d: got periph=%b core=%b ready=%b cause=%b, want periph=%b core=%b ready=%b cause=%b",
                     nm, idx, rif.rst_periph_no, rif.rst_core_no, rif.ready_o, rif.rst_cause_o,
                     periph, core, ready, cause);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            rst_ni           = tbl[i].rst_n;
            rif.pll_locked_i = tbl[i].pll;
            rif.ext_btn_ni   = tbl[i].btn;
            rif.sw_rst_req_i = tbl[i].sw;
            tick();
            check(ph_name(tbl[i].ph), i, tbl[i].periph, tbl[i].core, tbl[i].ready, tbl[i].cause);
        end
        tbl.delete();
    endtask

    // Release from reset with lock and button good: 2-cycle sync, HOLD at edge 3,
    // periph at edge 7, core at edge 9.
    task automatic add_release(input logic [2:0] ph);
        add(6, ph, 1, 1, 1, 0, 0, 0, 0, 4'b0001);
        add(2, ph, 1, 1, 1, 0, 1, 0, 0, 4'b0001);
        add(2, ph, 1, 1, 1, 0, 1, 1, 1, 4'b0001);
    endtask

    initial begin
        rif.pll_locked_i = 1'b1;
        rif.ext_btn_ni   = 1'b1;
        rif.sw_rst_req_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1 check("reset_state", 0, 0, 0, 0, 4'b0001);

        // power-on
        add(1, 0, 0, 1, 1, 0, 0, 0, 0, 4'b0001);
        add_release(0);

        // PLL drop for 3 cycles in RUN: seen 2 edges later, resets low on the next
        add(2, 1, 1, 0, 1, 0, 1, 1, 1, 4'b0001);
        add(1, 1, 1, 0, 1, 0, 0, 0, 0, 4'b0010);
        add(6, 1, 1, 1, 1, 0, 0, 0, 0, 4'b0010);
        add(2, 1, 1, 1, 1, 0, 1, 0, 0, 4'b0010);
        add(1, 1, 1, 1, 1, 0, 1, 1, 1, 4'b0010);

        // 5-cycle button glitch: debounce never reaches 8
        add(5, 2, 1, 1, 0, 0, 1, 1, 1, 4'b0010);
        add(5, 2, 1, 1, 1, 0, 1, 1, 1, 4'b0010);

        // 12-cycle button press: debounced low at edge 10, reset at 11,
        // release needs 8 stable high cycles before HOLD at edge 23
        add(10, 3, 1, 1, 0, 0, 1, 1, 1, 4'b0010);
        add(2,  3, 1, 1, 0, 0, 0, 0, 0, 4'b0100);
        add(14, 3, 1, 1, 1, 0, 0, 0, 0, 4'b0100);
        add(2,  3, 1, 1, 1, 0, 1, 0, 0, 4'b0100);
        add(1,  3, 1, 1, 1, 0, 1, 1, 1, 4'b0100);

        // sw pulse coinciding with synced PLL loss, then sw in REL_PERIPH,
        // then a second sw pulse while in ASSERT that must not touch the cause
        add(2, 4, 1, 0, 1, 0, 1, 1, 1, 4'b0100);
        add(1, 4, 1, 0, 1, 1, 0, 0, 0, 4'b1010);
        add(6, 4, 1, 1, 1, 0, 0, 0, 0, 4'b1010);
        add(1, 4, 1, 1, 1, 0, 1, 0, 0, 4'b1010);
        add(1, 4, 1, 1, 1, 1, 0, 0, 0, 4'b1000);
        add(1, 4, 1, 1, 1, 1, 0, 0, 0, 4'b1000);
        add(3, 4, 1, 1, 1, 0, 0, 0, 0, 4'b1000);
        add(2, 4, 1, 1, 1, 0, 1, 0, 0, 4'b1000);
        add(1, 4, 1, 1, 1, 0, 1, 1, 1, 4'b1000);
        run_tbl();

        // sw from RUN into HOLD, then async reset mid-HOLD
        rif.sw_rst_req_i = 1'b1;
        tick();
        check("sw_run", 0, 0, 0, 0, 4'b1000);
        rif.sw_rst_req_i = 1'b0;
        tick();
        check("sw_to_hold", 0, 0, 0, 0, 4'b1000);
        tick();
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1 check("async_hold", 0, 0, 0, 0, 4'b0001);
        tick();
        tick();
        check("held_in_reset", 0, 0, 0, 0, 4'b0001);

        add_release(5);
        run_tbl();

        // async reset while fully released must drop outputs without an edge
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1 check("async_run", 0, 0, 0, 0, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
